// File: rtl/md5_msg_ctrl.sv
// md5_msg_ctrl
//   Message sequencer in front of md5_core_block. Packs a little-endian 32-bit
//   word stream into 512-bit blocks, appends the 0x80 marker and the 64-bit
//   bit length, issues one block at a time to the core, chains each block's
//   result into the next IV and returns the canonical 128-bit digest.
//   Only one message is in flight; the next is accepted once the digest is taken.
//
// Ports
//   clk_i, reset_i              clock (rising edge), async active-high reset
//   in_valid_i / in_ready_o     word stream handshake
//   in_data_i [31:0]            message word, byte 0 in [7:0]
//   in_last_i, in_bytes_i[2:0]  final word flag, valid bytes (values >4 read as 4)
//   core_start_o                1-cycle pulse per block
//   core_block_o [511:0]        word i at [32i+31:32i], stable start..done
//   core_iv_o [127:0]           {A,B,C,D}, stable start..done
//   core_done_i, core_chain_i   core result pulse and chained {A,B,C,D}
//   dig_valid_o / dig_ready_i   digest handshake
//   dig_data_o [127:0]          digest, [127:120] = A[7:0] ... [7:0] = D[31:24]
module md5_msg_ctrl #(
  parameter logic [31:0] IV_A = 32'h67452301,
  parameter logic [31:0] IV_B = 32'hefcdab89,
  parameter logic [31:0] IV_C = 32'h98badcfe,
  parameter logic [31:0] IV_D = 32'h10325476
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_bytes_i,
  output logic         core_start_o,
  output logic [511:0] core_block_o,
  output logic [127:0] core_iv_o,
  input  logic         core_done_i,
  input  logic [127:0] core_chain_i,
  output logic         dig_valid_o,
  input  logic         dig_ready_i,
  output logic [127:0] dig_data_o
);

  localparam logic [127:0] IV = {IV_A, IV_B, IV_C, IV_D};

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_RUN, S_WAIT, S_PAD2, S_DONE
  } state_t;

  // where the message ended inside the current block
  typedef struct packed {
    logic [3:0] idx;
    logic [2:0] nb;
  } tail_t;

  state_t            state_q;
  logic [15:0][31:0] blk_q;
  logic [127:0]      iv_q;
  logic [127:0]      dig_q;
  logic [63:0]       cnt_q;
  logic [3:0]        widx_q;
  tail_t             tail_q;
  logic              final_q;    // block being compressed is the last one
  logic              pad2_q;     // a length-only block must follow
  logic              pad2_80_q;  // that block also carries the 0x80 marker
  logic              in_ready_q;
  logic              start_q;
  logic              dvld_q;

  // incoming word with bytes above in_bytes cleared and the marker inserted
  logic [2:0]   nb_d;
  logic [31:0]  mask_d;
  logic [31:0]  mark_d;
  logic [31:0]  word_d;
  logic         accept_d;
  logic [4:0]   pos80_d;
  logic [63:0]  cnt_d;
  logic [127:0] chain_sw_d;

  assign nb_d = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;

  always_comb begin
    mask_d = 32'h0;
    case (nb_d)
      3'd0:    mask_d = 32'h0000_0000;
      3'd1:    mask_d = 32'h0000_00ff;
      3'd2:    mask_d = 32'h0000_ffff;
      3'd3:    mask_d = 32'h00ff_ffff;
      default: mask_d = 32'hffff_ffff;
    endcase
  end

  assign mark_d   = (in_last_i && nb_d != 3'd4) ? (32'h80 << {nb_d[1:0], 3'b000}) : 32'h0;
  assign word_d   = (in_data_i & mask_d) | mark_d;
  assign accept_d = in_valid_i && in_ready_q && (state_q == S_IDLE || state_q == S_FILL);
  assign cnt_d    = cnt_q + {58'd0, nb_d, 3'b000};
  // a full last word pushes the marker into the following word (may be 16)
  assign pos80_d  = {1'b0, tail_q.idx} + {4'd0, (tail_q.nb == 3'd4)};

  // per-word byte reversal of the chain into canonical digest order
  for (genvar w = 0; w < 4; w++) begin : g_sw_w
    for (genvar b = 0; b < 4; b++) begin : g_sw_b
      assign chain_sw_d[127-32*w-8*b -: 8] = core_chain_i[32*(3-w)+8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      iv_q       <= IV;
      dig_q      <= '0;
      cnt_q      <= '0;
      widx_q     <= '0;
      tail_q     <= '0;
      final_q    <= 1'b0;
      pad2_q     <= 1'b0;
      pad2_80_q  <= 1'b0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      dvld_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            blk_q[widx_q] <= word_d;
            cnt_q         <= cnt_d;
            widx_q        <= widx_q + 4'd1;
            if (in_last_i) begin
              tail_q     <= '{idx: widx_q, nb: nb_d};
              in_ready_q <= 1'b0;
              state_q    <= S_PAD;
            end else if (widx_q == 4'd15) begin
              final_q    <= 1'b0;
              pad2_q     <= 1'b0;
              in_ready_q <= 1'b0;
              state_q    <= S_RUN;
            end else begin
              state_q    <= S_FILL;
            end
          end
        end
        S_PAD: begin
          widx_q <= '0;
          if (tail_q.nb == 3'd4 && tail_q.idx != 4'd15)
            blk_q[tail_q.idx + 4'd1] <= 32'h0000_0080;
          if (pos80_d <= 5'd13) begin
            blk_q[14] <= cnt_q[31:0];
            blk_q[15] <= cnt_q[63:32];
            final_q   <= 1'b1;
            pad2_q    <= 1'b0;
          end else begin
            // no room for the length: send this block as is, length follows
            final_q   <= 1'b0;
            pad2_q    <= 1'b1;
            pad2_80_q <= (pos80_d == 5'd16);
          end
          state_q <= S_RUN;
        end
        S_RUN: begin
          start_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          start_q <= 1'b0;
          if (core_done_i) begin
            iv_q  <= core_chain_i;
            blk_q <= '0;  // later words of the next block must read as zero
            if (final_q) begin
              dig_q   <= chain_sw_d;
              dvld_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (pad2_q) begin
              state_q <= S_PAD2;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_FILL;
            end
          end
        end
        S_PAD2: begin
          blk_q[0]  <= pad2_80_q ? 32'h0000_0080 : 32'h0;
          blk_q[14] <= cnt_q[31:0];
          blk_q[15] <= cnt_q[63:32];
          final_q   <= 1'b1;
          pad2_q    <= 1'b0;
          state_q   <= S_RUN;
        end
        S_DONE: begin
          if (dig_ready_i) begin
            dvld_q     <= 1'b0;
            iv_q       <= IV;
            cnt_q      <= '0;
            widx_q     <= '0;
            final_q    <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign core_start_o = start_q;
  assign core_block_o = blk_q;
  assign core_iv_o    = iv_q;
  assign dig_valid_o  = dvld_q;
  assign dig_data_o   = dig_q;

endmodule

// File: tb/tb_md5_msg_ctrl.sv
// Bench for md5_msg_ctrl: a behavioural MD5 core answers each block after a
// random latency, a consumer with random ready pops expected digests from a
// scoreboard queue, and a vector table plus hand sequences drive messages.
module tb_md5_msg_ctrl;
  localparam logic [127:0] IV = 128'h67452301efcdab8998badcfe10325476;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         core_start, core_done = 1'b0;
  logic [511:0] core_block;
  logic [127:0] core_iv, core_chain = '0;
  logic         dig_valid, dig_ready = 1'b0;
  logic [127:0] dig_data;

  always #5 clk = ~clk;

  md5_msg_ctrl dut (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .in_bytes_i(in_bytes),
    .core_start_o(core_start), .core_block_o(core_block), .core_iv_o(core_iv),
    .core_done_i(core_done), .core_chain_i(core_chain),
    .dig_valid_o(dig_valid), .dig_ready_i(dig_ready), .dig_data_o(dig_data)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference MD5 ----------------
  logic [31:0] kt[64];
  int          sr[16];

  function automatic logic [127:0] md5_comp(input logic [127:0] iv, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f;
    int g, s;
    a = iv[127:96]; b = iv[95:64]; c = iv[63:32]; d = iv[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      f = f + a + kt[i] + blk[32*g +: 32];
      s = sr[(i / 16) * 4 + (i % 4)];
      a = d; d = c; c = b;
      b = b + ((f << s) | (f >> (32 - s)));
    end
    return {iv[127:96] + a, iv[95:64] + b, iv[63:32] + c, iv[31:0] + d};
  endfunction

  function automatic logic [127:0] md5_ref(input byte m[], input int len);
    byte          p[];
    int           pl;
    logic [63:0]  bits;
    logic [127:0] h, r;
    logic [511:0] blk;
    pl = ((len + 8) / 64 + 1) * 64;
    p = new[pl];
    for (int i = 0; i < pl; i++) p[i] = 8'h00;
    for (int i = 0; i < len; i++) p[i] = m[i];
    p[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) p[pl-8+i] = bits[8*i +: 8];
    h = IV;
    for (int k = 0; k < pl / 64; k++) begin
      for (int i = 0; i < 64; i++) blk[8*i +: 8] = p[64*k+i];
      h = md5_comp(h, blk);
    end
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) r[127-32*w-8*b -: 8] = h[32*(3-w)+8*b +: 8];
    return r;
  endfunction

  function automatic logic [511:0] pack(input byte m[], input int off, input int n);
    logic [511:0] blk;
    blk = '0;
    for (int i = 0; i < n; i++) blk[8*i +: 8] = m[off+i];
    return blk;
  endfunction

  // ---------------- core model ----------------
  logic [511:0] blk_log[$];
  logic [127:0] iv_log[$], chn_log[$];
  logic [511:0] cur_blk;
  logic [127:0] cur_iv;
  bit           busy = 0, spurious = 0;
  int           lat = 0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (rst) begin
      busy = 0;
    end else begin
      if (busy) begin
        if (lat == 0) begin
          chk("blk_stable", core_block, cur_blk);
          chk("iv_stable", core_iv, cur_iv);
          core_chain = md5_comp(cur_iv, cur_blk);
          chn_log.push_back(core_chain);
          core_done = 1'b1;
          busy = 0;
        end else lat--;
      end else if (spurious) begin
        core_chain = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        core_done  = 1'b1;
        spurious   = 0;
      end
      if (core_start) begin
        chk("one_outstanding", busy, 0);
        busy = 1;
        lat = $urandom_range(4, 1);
        cur_blk = core_block;
        cur_iv  = core_iv;
        blk_log.push_back(core_block);
        iv_log.push_back(core_iv);
      end
    end
  end

  // ---------------- digest consumer / scoreboard ----------------
  logic [127:0] exp_q[$];
  int           ndig = 0;
  bit           hold_rdy = 0;

  always @(negedge clk) begin
    if (rst) begin
      dig_ready = 1'b0;
    end else begin
      dig_ready = hold_rdy ? 1'b0 : ($urandom_range(3, 0) != 0);
      if (dig_valid && dig_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_digest act=%0h exp=none", dig_data);
        end else chk("digest", dig_data, exp_q.pop_front());
        ndig++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input byte m[], input int len, input bit tail0, input bit big);
    int nw, nb, t;
    logic [31:0] d;
    nw = (len == 0) ? 1 : (len + 3) / 4;
    if (tail0 && len > 0 && len % 4 == 0) nw++;
    for (int w = 0; w < nw; w++) begin
      nb = len - 4 * w;
      if (nb > 4) nb = 4;
      if (nb < 0) nb = 0;
      d = $urandom;  // unused bytes carry garbage
      for (int b = 0; b < nb; b++) d[8*b +: 8] = m[4*w+b];
      in_valid = 1'b0;
      repeat ($urandom_range(1, 0)) tick;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      in_bytes = (nb == 4 && big) ? 3'(5 + $urandom_range(2, 0)) : 3'(nb);
      t = 0;
      while (!in_ready && t < 300) begin tick; t++; end
      if (t >= 300) begin
        checks++; failures++;
        $display("FAIL in_ready_timeout act=0 exp=1");
      end
      tick;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input string name, input byte m[], input int len, input logic [127:0] e,
                         input int nblk, input bit tail0, input bit big);
    int t, target;
    blk_log.delete(); iv_log.delete(); chn_log.delete();
    exp_q.push_back(e);
    target = ndig + 1;
    send(m, len, tail0, big);
    t = 0;
    while (ndig < target && t < 3000) begin tick; t++; end
    if (t >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_digest_timeout act=%0d exp=%0d", name, ndig, target);
      exp_q.delete();
    end
    chk({name, "_nblk"}, blk_log.size(), nblk);
    if (iv_log.size() > 0) chk({name, "_iv0"}, iv_log[0], IV);
    for (int j = 1; j < iv_log.size() && j <= chn_log.size(); j++)
      chk($sformatf("%s_chain%0d", name, j), iv_log[j], chn_log[j-1]);
  endtask

  typedef struct {
    string        s;
    int           len;   // -1: message is s, else generated bytes of this length
    logic [127:0] dig;   // 0: digest from the reference model
    int           nblk;
    bit           tail0;
    bit           big;
  } vec_t;

  vec_t vt[12];

  initial begin : main
    byte          m[];
    int           len, t, nd;
    logic [127:0] e, cap;
    logic [511:0] xb;
    real          r;

    sr = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'($rtoi($floor(r * 4294967296.0) - 2147483648.0)) + 32'h8000_0000;
    end

    vt[0]  = '{"", -1, 128'hd41d8cd98f00b204e9800998ecf8427e, 1, 0, 0};
    vt[1]  = '{"abc", -1, 128'h900150983cd24fb0d6963f7d28e17f72, 1, 0, 0};
    vt[2]  = '{"a", -1, 128'h0cc175b9c0f1b6a831c399e269772661, 1, 0, 0};
    vt[3]  = '{"message digest", -1, 128'hf96b697d7cb7938d525a2f31aaf161d0, 1, 0, 1};
    vt[4]  = '{"The quick brown fox jumps over the lazy dog", -1,
               128'h9e107d9d372bb6826bd81d3542a419d6, 1, 0, 0};
    vt[5]  = '{"12345678901234567890123456789012345678901234567890123456789012345678901234567890",
               -1, 128'h57edf4a22be3c955ac49da2e2107b67a, 2, 1, 0};
    vt[6]  = '{"", 55, 128'h0, 1, 0, 0};
    vt[7]  = '{"", 56, 128'h0, 2, 1, 1};
    vt[8]  = '{"", 63, 128'h0, 2, 0, 0};
    vt[9]  = '{"", 64, 128'h0, 2, 1, 0};
    vt[10] = '{"", 120, 128'h0, 3, 0, 0};
    vt[11] = '{"", 128, 128'h0, 3, 0, 1};

    // reset state
    tick; tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_core_iv", core_iv, IV);
    chk("rst_dig_data", dig_data, 0);
    rst = 1'b0;
    chk("rst_rel_in_ready", in_ready, 0);
    tick;
    chk("in_ready_after_rst", in_ready, 1);

    // vector table
    for (int i = 0; i < 12; i++) begin
      if (vt[i].len < 0) begin
        len = vt[i].s.len();
        m = new[len];
        for (int j = 0; j < len; j++) m[j] = vt[i].s[j];
      end else begin
        len = vt[i].len;
        m = new[len];
        for (int j = 0; j < len; j++) m[j] = 8'(j * 7 + len + 1);
      end
      e = (vt[i].dig != 128'h0) ? vt[i].dig : md5_ref(m, len);
      run_msg($sformatf("vec%0d", i), m, len, e, vt[i].nblk, vt[i].tail0, vt[i].big);
      if (i == 0) chk("empty_blk", blk_log[0], 512'h80);
      if (i == 1) begin
        xb = '0;
        xb[31:0] = 32'h80636261;
        xb[32*14 +: 32] = 32'h18;
        chk("abc_blk", blk_log[0], xb);
      end
    end

    // 56 bytes: marker fills word 14, length in a second block
    len = 56; m = new[len];
    for (int j = 0; j < len; j++) m[j] = 8'(j ^ 8'h5a);
    run_msg("m56", m, len, md5_ref(m, len), 2, 0, 0);
    xb = pack(m, 0, 56);
    xb[32*14 +: 32] = 32'h80;
    chk("m56_blk0", blk_log[0], xb);
    xb = '0;
    xb[32*14 +: 32] = 32'h1C0;
    chk("m56_blk1", blk_log[1], xb);

    // 64 bytes: pure data block, then marker + length block
    len = 64; m = new[len];
    for (int j = 0; j < len; j++) m[j] = 8'(255 - j);
    run_msg("m64", m, len, md5_ref(m, len), 2, 0, 0);
    chk("m64_blk0", blk_log[0], pack(m, 0, 64));
    xb = '0;
    xb[31:0] = 32'h80;
    xb[32*14 +: 32] = 32'h200;
    chk("m64_blk1", blk_log[1], xb);

    // digest held while consumer stalls
    m = new[3]; m[0] = 8'h61; m[1] = 8'h62; m[2] = 8'h63;
    hold_rdy = 1;
    exp_q.push_back(128'h900150983cd24fb0d6963f7d28e17f72);
    nd = ndig;
    send(m, 3, 0, 0);
    t = 0;
    while (!dig_valid && t < 500) begin tick; t++; end
    chk("hold_dig_valid_seen", dig_valid, 1);
    cap = dig_data;
    chk("hold_dig_value", cap, 128'h900150983cd24fb0d6963f7d28e17f72);
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("hold_valid%0d", k), dig_valid, 1);
      chk($sformatf("hold_data%0d", k), dig_data, cap);
      chk($sformatf("hold_in_ready%0d", k), in_ready, 0);
    end
    hold_rdy = 0;
    t = 0;
    while (ndig == nd && t < 100) begin tick; t++; end
    chk("hold_popped", ndig, nd + 1);
    m = new[1]; m[0] = 8'h61;
    run_msg("after_hold", m, 1, 128'h0cc175b9c0f1b6a831c399e269772661, 1, 0, 0);

    // core_done while idle must be ignored
    spurious = 1;
    tick; tick; tick;
    chk("spur_iv", core_iv, IV);
    chk("spur_dig_valid", dig_valid, 0);
    chk("spur_in_ready", in_ready, 1);
    m = new[3]; m[0] = 8'h61; m[1] = 8'h62; m[2] = 8'h63;
    run_msg("after_spur", m, 3, 128'h900150983cd24fb0d6963f7d28e17f72, 1, 0, 0);

    // reset while waiting on the core
    len = 20; m = new[len];
    for (int j = 0; j < len; j++) m[j] = 8'(j + 3);
    blk_log.delete();
    nd = ndig;
    send(m, len, 0, 0);
    t = 0;
    while (blk_log.size() == 0 && t < 100) begin tick; t++; end
    chk("wait_reached", blk_log.size(), 1);
    rst = 1'b1;
    #1;
    chk("wrst_in_ready", in_ready, 0);
    chk("wrst_core_start", core_start, 0);
    chk("wrst_dig_valid", dig_valid, 0);
    chk("wrst_core_block", core_block, 0);
    chk("wrst_core_iv", core_iv, IV);
    chk("wrst_dig_data", dig_data, 0);
    tick; tick;
    rst = 1'b0;
    repeat (20) tick;
    chk("wrst_no_digest", ndig, nd);
    chk("wrst_no_valid", dig_valid, 0);
    m = new[3]; m[0] = 8'h61; m[1] = 8'h62; m[2] = 8'h63;
    run_msg("after_rst", m, 3, 128'h900150983cd24fb0d6963f7d28e17f72, 1, 0, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
